// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the MMIO initiator: response codes,
// default protection attribute and the master FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } axi_master_state_t;

  // Anything other than a plain OKAY is reported to the core as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns the core's single-request memory port into
// AR/R or AW/W/B transactions, one outstanding at a time, no bursts.
// Optional build macro AXI_TIMEOUT_EN adds a watchdog that abandons a
// transaction after TIMEOUT_CYCLES cycles outside IDLE and reports an error.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  // core request/response port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  // read address channel
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [2:0]            axi_arprot,
  // read data channel
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  // write address channel
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [2:0]            axi_awprot,
  // write data channel
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  // write response channel
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready
);

  localparam int STRB_W = DATA_W / 8;

  // A watchdog shorter than two cycles cannot let any handshake complete.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi_lite_master: TIMEOUT_CYCLES must be at least 2");
  end

  axi_master_state_t   state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Next-state, channel control and response generation.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; without this the tool would infer latches.
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef AXI_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (axi_rvalid) begin
          resp_rdata_d = axi_rdata;
          resp_err_d   = resp_is_err(axi_rresp);
          resp_valid_d = 1'b1;
          rready_d     = 1'b0;
          state_d      = IDLE;
        end
      end

      WR_REQ: begin
        // AW and W complete independently; each valid drops only on its ready.
        if (awvalid_q && axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (axi_bvalid) begin
          resp_rdata_d = '0;
          resp_err_d   = resp_is_err(axi_bresp);
          resp_valid_d = 1'b1;
          bready_d     = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef AXI_TIMEOUT_EN
    // Watchdog: abandon the transaction and report an error on expiry.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      cnt_d        = '0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b1;
      resp_valid_d = 1'b1;
      state_d      = IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif

    // Accept a new request only once the response pulse has been seen.
    req_ready_d = (state_d == IDLE) && !resp_valid_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef AXI_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef AXI_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

  assign axi_araddr  = addr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_arprot  = AXI_PROT_DEFAULT;
  assign axi_rready  = rready_q;

  assign axi_awaddr  = addr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awprot  = AXI_PROT_DEFAULT;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI4-Lite initiator bridging the core's single-request memory port onto the MMIO bus that serves CLINT-style responders.
- Accepts one read or write request at a time, drives AR/R or AW/W/B, and returns data and an error flag to the core.
- Sits between the core load/store unit and the MMIO interconnect.
- One outstanding transaction; no bursts.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with AXI_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge idle; can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte enables
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_rdata  out  DATA_W  read data; 0 for writes
- resp_err  out  1  bus returned SLVERR/DECERR, or timeout
- axi_araddr  out  ADDR_W; axi_arvalid  out  1; axi_arready  in  1; axi_arprot  out  3 (constant 3'b000)
- axi_rdata  in  DATA_W; axi_rresp  in  2; axi_rvalid  in  1; axi_rready  out  1
- axi_awaddr  out  ADDR_W; axi_awvalid  out  1; axi_awready  in  1; axi_awprot  out  3 (constant 3'b000)
- axi_wdata  out  DATA_W; axi_wstrb  out  DATA_W/8; axi_wvalid  out  1; axi_wready  in  1
- axi_bresp  in  2; axi_bvalid  in  1; axi_bready  out  1

Behaviour:
- Reset values:
  - req_ready=1.
  - All axi_*valid=0; axi_rready=0; axi_bready=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - Address, data and strobe outputs=0.
  - State=IDLE.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata and wstrb and drop req_ready.
  - If req_we=0: set axi_arvalid and go to RD_ADDR.
  - If req_we=1: set axi_awvalid and axi_wvalid and go to WR_REQ.
  - Latency from request to the first AXI valid is 1 cycle.
- RD_ADDR:
  - Hold araddr and arvalid stable until arready.
  - On arready: arvalid=0, rready=1, go to RD_DATA.
- RD_DATA:
  - On rvalid with rready: capture rdata; resp_err = (rresp != 2'b00).
  - Pulse resp_valid for 1 cycle, rready=0, go to IDLE.
- WR_REQ: the AW and W channels are independent.
  - Clear awvalid when awready is seen; clear wvalid when wready is seen.
  - Track completion in aw_done and w_done.
  - Both handshakes may occur in the same cycle or in either order.
  - Once both are done: bready=1, go to WR_RESP.
  - Valid signals never drop before their ready is seen.
- WR_RESP:
  - On bvalid: resp_err = (bresp != 2'b00); resp_rdata=0.
  - Pulse resp_valid, bready=0, go to IDLE.
- The core must not issue a new request until resp_valid. req_ready reasserts in the cycle after resp_valid.
- Reset mid-transaction: all valids drop immediately and the transaction is abandoned. No resp_valid is emitted.
- Input rvalid or bvalid arriving while not in the corresponding wait state is ignored.

Optional Feature:
- Macro: AXI_TIMEOUT_EN.
- Defined:
  - A counter clears on leaving IDLE and increments every cycle in a non-IDLE state.
  - On reaching TIMEOUT_CYCLES: all valids and readies drop, resp_valid=1 with resp_err=1, resp_rdata=0, state returns to IDLE.
  - Any late AXI response is then dropped.
- Undefined: no counter exists; the bridge waits indefinitely.

Decomposition:
- Package axi_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum axi_master_state_t.
  - Default PROT value.
- No sub-module is needed. The timeout counter stays inline.

Test Plan:
- Read 0x0000BFF8: arready at cycle 2, rvalid with rdata=0x12345678 and rresp=00 at cycle 4 -> resp_valid one cycle, rdata=0x12345678, err=0, req_ready back next cycle.
- Write 0x4000 with wdata=0xDEADBEEF and wstrb=4'b0011: awready 3 cycles before wready -> awvalid drops first, wvalid held with data and strobe stable; bvalid with bresp=00 -> resp_valid, err=0.
- Write with awready and wready in the same cycle, then bresp=2'b10 -> a single resp_valid with err=1.
- Read returning rresp=2'b11 -> err=1 and rdata is passed through; a back-to-back second request is accepted only after req_ready.
- rstn=0 asserted while in WR_RESP -> all valids and readies are 0 the next cycle, no resp_valid, state IDLE.
- AXI_TIMEOUT_EN with TIMEOUT_CYCLES=16 and arready held at 0 -> resp_valid with err=1 at cycle 16 and arvalid dropped. Without the macro, arvalid stays at 1 indefinitely.
